// File: rtl/sr_ff_ctrl_pkg.sv
// Shared definitions for the SR flip-flop command controller.
package sr_ff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        VERIFY = 2'd2
    } state_e;

    localparam int HOLD_CYC_DEF = 2;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/sr_ff_ctrl_arb.sv
// Two-requester round-robin grant; the requester not granted last wins a tie.
module sr_arb2
    import sr_ff_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic set_req_i,
    input  logic rst_req_i,
    output logic set_gnt_o,
    output logic rst_gnt_o
);

    // 1: set won last, 0: reset won last (reset value, so set wins first tie)
    logic last_set_q, last_set_d;

    always_comb begin
        set_gnt_o  = en_i && set_req_i && (!rst_req_i || !last_set_q);
        rst_gnt_o  = en_i && rst_req_i && (!set_req_i ||  last_set_q);
        last_set_d = last_set_q;
        if (set_gnt_o) begin
            last_set_d = 1'b1;
        end else if (rst_gnt_o) begin
            last_set_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_set_q <= 1'b0;
        end else begin
            last_set_q <= last_set_d;
        end
    end

endmodule

// File: rtl/sr_ff_ctrl.sv
// Sequences set/reset commands onto an external SR flip-flop and verifies q.
module sr_ff_ctrl
    import sr_ff_ctrl_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic set_gnt,
    output logic rst_gnt,
    output logic s,
    output logic r,
    input  logic q,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             arb_en;

    // Gating with rst_n keeps grants quiet while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;

    sr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (arb_en),
        .set_req_i (set_req),
        .rst_req_i (rst_req),
        .set_gnt_o (set_gnt),
        .rst_gnt_o (rst_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (set_gnt || rst_gnt) state_d = DRIVE;
            DRIVE:   if (cnt_q == '0)        state_d = VERIFY;
            VERIFY:                          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        tgt_d  = tgt_q;
        s_d    = 1'b0;
        r_d    = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_gnt || rst_gnt) begin
                    cnt_d = HOLD_LOAD;
                    tgt_d = set_gnt;
                    s_d   = set_gnt;
                    r_d   = rst_gnt;
                end
            end
            DRIVE: begin
                // Drive continues until the counter reaches zero; it never wraps.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    s_d   = tgt_q;
                    r_d   = !tgt_q;
                end
            end
            VERIFY: begin
                done_d = (q == tgt_q);
                err_d  = (q != tgt_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tgt_q  <= 1'b0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
            s_q    <= s_d;
            r_q    <= r_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sr_ff_ctrl.sv
// Scoreboard bench for sr_ff_ctrl driving a behavioural SR flip-flop.
module tb_sr_ff_ctrl;

    localparam int H = 2;
    localparam int P = H + 2;

    localparam int EV_SG   = 0;
    localparam int EV_RG   = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int cyc;
        int ns;
        int nr;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n, set_req, rst_req, stuck;
    logic set_gnt, rst_gnt, s, r, q, busy, done, err;
    logic ff_q = 1'b0;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ns_cnt = 0;
    int   nr_cnt = 0;
    int   c;
    ev_t  sb[$];

    sr_ff_ctrl #(.HOLD_CYC(H), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .rst_req (rst_req),
        .set_gnt (set_gnt),
        .rst_gnt (rst_gnt),
        .s       (s),
        .r       (r),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SR flip-flop; stuck forces the read-back low.
    always @(posedge clk) begin
        if (s)      ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end
    assign q = stuck ? 1'b0 : ff_q;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int ns, input int nr);
        ev_t e;
        e.kind = kind; e.cyc = at; e.ns = ns; e.nr = nr;
        sb.push_back(e);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_ev", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cyc", cyc, e.cyc);
            if (kind == EV_DONE || kind == EV_ERR) begin
                chk("s_hold", ns_cnt, e.ns);
                chk("r_hold", nr_cnt, e.nr);
            end else begin
                ns_cnt = 0;
                nr_cnt = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        chk("s_and_r", int'(s & r), 0);
        chk("done_and_err", int'(done & err), 0);
        if (s) ns_cnt++;
        if (r) nr_cnt++;
        if (done)    handle(EV_DONE);
        if (err)     handle(EV_ERR);
        if (set_gnt) handle(EV_SG);
        if (rst_gnt) handle(EV_RG);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; set_req = 1'b1; rst_req = 1'b0; stuck = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_set_gnt", set_gnt, 0);
        step(2);
        set_req = 1'b0;
        rst_n = 1'b1;
        step(1);

        // single set command
        set_req = 1'b1; c = cyc;
        push(EV_SG, c, 0, 0); push(EV_DONE, c + P, H, 0);
        step(1); set_req = 1'b0;
        step(P + 1);
        chk("q_after_set", ff_q, 1);

        // single reset command
        rst_req = 1'b1; c = cyc;
        push(EV_RG, c, 0, 0); push(EV_DONE, c + P, 0, H);
        step(1); rst_req = 1'b0;
        step(P + 1);
        chk("q_after_rst", ff_q, 0);

        // continuous conflict alternates set, reset, set, reset
        set_req = 1'b1; rst_req = 1'b1; c = cyc;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push(EV_SG, c + k * P, 0, 0); push(EV_DONE, c + (k + 1) * P, H, 0);
            end else begin
                push(EV_RG, c + k * P, 0, 0); push(EV_DONE, c + (k + 1) * P, 0, H);
            end
        end
        step(3 * P + 1);
        set_req = 1'b0; rst_req = 1'b0;
        step(P + 2);
        chk("q_after_conflict", ff_q, 0);

        // q stuck low during set -> err
        stuck = 1'b1; set_req = 1'b1; c = cyc;
        push(EV_SG, c, 0, 0); push(EV_ERR, c + P, H, 0);
        step(1); set_req = 1'b0;
        step(P + 1);
        chk("busy_after_err", busy, 0);
        stuck = 1'b0;

        // reset pulled in the second drive cycle
        rst_req = 1'b1; c = cyc;
        push(EV_RG, c, 0, 0);
        step(1); rst_req = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("abort_s", s, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(P + 2);
        set_req = 1'b1; c = cyc;
        push(EV_SG, c, 0, 0); push(EV_DONE, c + P, H, 0);
        step(1); set_req = 1'b0;
        step(P + 1);
        chk("q_after_abort_set", ff_q, 1);

        // set request raised while busy is served when IDLE is reached
        rst_req = 1'b1; c = cyc;
        push(EV_RG, c, 0, 0); push(EV_DONE, c + P, 0, H);
        push(EV_SG, c + P, 0, 0); push(EV_DONE, c + 2 * P, H, 0);
        step(1); rst_req = 1'b0; set_req = 1'b1;
        chk("busy_in_drive", busy, 1);
        step(1);
        chk("no_gnt_busy", set_gnt, 0);
        step(P - 1); set_req = 1'b0;
        step(P + 2);
        chk("q_after_queue", ff_q, 1);

        step(3);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sr_ff_ctrl.md
SR_FF_CTRL -- requirements
Module: sr_ff_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 2, number of clk cycles s or r is held high per command (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, width of the hold counter.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 set_req  input  1  requester A asks for q=1; level, held until set_gnt.
REQ-006 rst_req  input  1  requester B asks for q=0; level, held until rst_gnt.
REQ-007 set_gnt  output  1  one-cycle pulse: set command accepted.
REQ-008 rst_gnt  output  1  one-cycle pulse: reset command accepted.
REQ-009 s  output  1  set drive to the SR flip-flop.
REQ-010 r  output  1  reset drive to the SR flip-flop.
REQ-011 q  input  1  flip-flop output, read back for verification.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse: command completed, q matched target.
REQ-014 err  output  1  one-cycle pulse: command completed, q mismatched target.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, VERIFY.
REQ-016 IDLE: with no request, SHALL remain in IDLE, s=r=0.
REQ-017 IDLE, exactly one request high: SHALL pulse that requester's gnt the same cycle, latch target (1=set, 0=reset), go to DRIVE next cycle.
REQ-018 IDLE, both requests high: SHALL grant round-robin -- winner is the requester not granted last; last-winner flag resets to "reset", so set wins the first conflict.
REQ-019 DRIVE: SHALL assert s (target 1) or r (target 0) for exactly HOLD_CYC consecutive cycles, then go to VERIFY.
REQ-020 s and r SHALL never be high in the same cycle, in any state, including reset.
REQ-021 s and r SHALL be registered outputs; first drive cycle is the cycle after the grant.
REQ-022 VERIFY: SHALL hold s=r=0 for one cycle, sample q, pulse done if q==target else err, return to IDLE.
REQ-023 Grant-to-done latency SHALL be HOLD_CYC+2 cycles; minimum spacing between grants HOLD_CYC+2 cycles.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE; no queueing.
REQ-025 A request withdrawn before grant SHALL not be granted; withdrawal after grant SHALL not abort the command.
REQ-026 Hold counter SHALL be CNT_W bits, load HOLD_CYC-1 on grant, decrement in DRIVE, exit at zero; no wrap.
REQ-027 done and err SHALL be mutually exclusive and each one cycle wide.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, s=0, r=0, set_gnt=0, rst_gnt=0, done=0, err=0, busy=0, counter=0, last-winner=reset.
REQ-029 Reset asserted mid-DRIVE or mid-VERIFY SHALL drop s and r immediately, emit no done/err; operation resumes from IDLE after rst_n release.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE=2'd0, DRIVE=2'd1, VERIFY=2'd2) and HOLD_CYC default.
REQ-031 One sub-module is natural: sr_arb2, the two-input round-robin grant with last-winner flag; FSM and counter stay in sr_ff_ctrl.
REQ-032 The existing sr_ff SHALL be instantiated only in the bench, not inside sr_ff_ctrl.

Verification
REQ-033 Reset then set_req=1, HOLD_CYC=2 -> set_gnt pulse, s high 2 cycles, r=0 throughout, done 4 cycles after grant, sr_ff q=1.
REQ-034 From q=1, rst_req=1 -> rst_gnt, r high 2 cycles, done, q=0.
REQ-035 set_req and rst_req both high continuously -> grants alternate set, reset, set, ...; s&r never both 1.
REQ-036 Bench forces q stuck at 0 during set command -> err pulse, no done, return to IDLE.
REQ-037 rst_n pulled low in 2nd DRIVE cycle -> s=r=0 immediately, no done/err, busy=0; next request served normally.
REQ-038 set_req raised while busy -> no set_gnt until IDLE, then granted the cycle IDLE is reached.
